// File: rtl/sseg_scan_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | sseg_scan_decoder                                                        |
// | Recovers current/setpoint temperatures from a scanned 8-digit 7-segment  |
// | display bus. Optional macro SSEG_SCAN_CHECK_EN enables F/degree checks.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sseg_scan_decoder #(
  parameter int unsigned SETTLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] an_in,
  input  logic [6:0] sseg_in,
  output logic [7:0] current_temp,
  output logic [7:0] changed_temp,
  output logic       frame_valid,
  output logic       decode_err
);

  localparam logic [7:0] c_settle    = 8'(SETTLE);
  localparam logic [7:0] c_settle_m1 = 8'(SETTLE - 1);
`ifdef SSEG_SCAN_CHECK_EN
  localparam logic [6:0] c_seg_f     = 7'b0111000;
  localparam logic [6:0] c_seg_deg   = 7'b0011100;
`endif

  typedef enum logic [0:0] {S_HUNT = 1'b0, S_COLLECT = 1'b1} state_t;

  logic [7:0] an_s1_q, an_s2_q, an_prev_q;
  logic [6:0] seg_s1_q, seg_s2_q, seg_prev_q;
  logic [7:0] cnt_q, cnt_d;
  logic       armed_q, armed_d;
  state_t     state_q, state_d;
  logic [2:0] exp_q, exp_d;
  logic [3:0] cur_ones_q, cur_ones_d, cur_tens_q, cur_tens_d;
  logic [3:0] chg_ones_q, chg_ones_d, chg_tens_q, chg_tens_d;
  logic       pend_q, pend_d;
  logic       err_q, err_d;
  logic       fv_q;
  logic [7:0] cur_temp_q, chg_temp_q;

  logic       w_same, w_an_chg, w_acc, w_blank, w_onehot, w_dig_ok, w_pat_ok;
  logic [7:0] w_low;
  logic [2:0] w_slot;
  logic [3:0] w_dig;

  // Two-flop synchronizer plus a one-deep history for change detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1_q    <= 8'hFF;
      an_s2_q    <= 8'hFF;
      an_prev_q  <= 8'hFF;
      seg_s1_q   <= 7'h7F;
      seg_s2_q   <= 7'h7F;
      seg_prev_q <= 7'h7F;
    end else begin
      an_s1_q    <= an_in;
      an_s2_q    <= an_s1_q;
      an_prev_q  <= an_s2_q;
      seg_s1_q   <= sseg_in;
      seg_s2_q   <= seg_s1_q;
      seg_prev_q <= seg_s2_q;
    end
  end

  assign w_same   = (an_s2_q == an_prev_q) && (seg_s2_q == seg_prev_q);
  assign w_an_chg = (an_s2_q != an_prev_q);
  assign w_acc    = w_same && armed_q && (cnt_q == c_settle_m1);
  assign w_low    = ~an_s2_q;
  assign w_blank  = (an_s2_q == 8'hFF);
  assign w_onehot = (w_low != 8'd0) && ((w_low & (w_low - 8'd1)) == 8'd0);

  // Counter saturates at SETTLE; a slot re-arms only when the anode changes
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (!w_same) begin
      cnt_d = 8'd0;
    end else if (cnt_q != c_settle) begin
      cnt_d = cnt_q + 8'd1;
    end
    if (w_an_chg) begin
      armed_d = 1'b1;
    end else if (w_acc) begin
      armed_d = 1'b0;
    end
  end

  always_comb begin
    w_slot = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_low[i]) w_slot = 3'(i);
    end
  end

  always_comb begin
    w_dig_ok = 1'b1;
    w_dig    = 4'd0;
    case (seg_s2_q)
      7'b0000001: w_dig = 4'd0;
      7'b1001111: w_dig = 4'd1;
      7'b0010010: w_dig = 4'd2;
      7'b0000110: w_dig = 4'd3;
      7'b1001100: w_dig = 4'd4;
      7'b0100100: w_dig = 4'd5;
      7'b0100000: w_dig = 4'd6;
      7'b0001111: w_dig = 4'd7;
      7'b0000000: w_dig = 4'd8;
      7'b0000100: w_dig = 4'd9;
      default:    w_dig_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_pat_ok = 1'b1;
    case (w_slot)
      3'd2, 3'd3, 3'd6, 3'd7: w_pat_ok = w_dig_ok;
`ifdef SSEG_SCAN_CHECK_EN
      3'd0, 3'd4:             w_pat_ok = (seg_s2_q == c_seg_f);
      default:                w_pat_ok = (seg_s2_q == c_seg_deg);
`else
      default:                w_pat_ok = 1'b1;
`endif
    endcase
  end

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    cur_ones_d = cur_ones_q;
    cur_tens_d = cur_tens_q;
    chg_ones_d = chg_ones_q;
    chg_tens_d = chg_tens_q;
    pend_d     = 1'b0;
    err_d      = 1'b0;
    if (w_acc && !w_blank) begin
      if (!w_onehot) begin
        err_d   = 1'b1;
        state_d = S_HUNT;
      end else if (state_q == S_HUNT) begin
        // Only slot 0 matters while hunting; other slots pass silently
        if (w_slot == 3'd0) begin
          if (w_pat_ok) begin
            state_d = S_COLLECT;
            exp_d   = 3'd1;
          end else begin
            err_d = 1'b1;
          end
        end
      end else if ((w_slot == exp_q) && w_pat_ok) begin
        case (w_slot)
          3'd2:    cur_ones_d = w_dig;
          3'd3:    cur_tens_d = w_dig;
          3'd6:    chg_ones_d = w_dig;
          3'd7:    chg_tens_d = w_dig;
          default: ;
        endcase
        if (w_slot == 3'd7) begin
          pend_d  = 1'b1;
          state_d = S_HUNT;
        end else begin
          exp_d = exp_q + 3'd1;
        end
      end else if ((w_slot == 3'd0) && w_pat_ok) begin
        exp_d = 3'd1;
      end else begin
        err_d   = 1'b1;
        state_d = S_HUNT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= 8'd0;
      armed_q    <= 1'b1;
      state_q    <= S_HUNT;
      exp_q      <= 3'd0;
      cur_ones_q <= 4'd0;
      cur_tens_q <= 4'd0;
      chg_ones_q <= 4'd0;
      chg_tens_q <= 4'd0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      fv_q       <= 1'b0;
      cur_temp_q <= 8'd0;
      chg_temp_q <= 8'd0;
    end else begin
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      state_q    <= state_d;
      exp_q      <= exp_d;
      cur_ones_q <= cur_ones_d;
      cur_tens_q <= cur_tens_d;
      chg_ones_q <= chg_ones_d;
      chg_tens_q <= chg_tens_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      fv_q       <= pend_q;
      if (pend_q) begin
        cur_temp_q <= 8'(cur_tens_q) * 8'd10 + 8'(cur_ones_q);
        chg_temp_q <= 8'(chg_tens_q) * 8'd10 + 8'(chg_ones_q);
      end
    end
  end

  assign current_temp = cur_temp_q;
  assign changed_temp = chg_temp_q;
  assign frame_valid  = fv_q;
  assign decode_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sseg_scan_decoder                                                     |
// | Randomized scan stimulus against a slot-level reference model.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sseg_scan_decoder;

  localparam int SETTLE = 16;
  localparam int LONG   = SETTLE + 12;
  localparam int GLITCH = SETTLE - 1;
  localparam logic [6:0] SEG_F   = 7'b0111000;
  localparam logic [6:0] SEG_DEG = 7'b0011100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] an_in;
  logic [6:0] sseg_in;
  logic [7:0] current_temp, changed_temp;
  logic       frame_valid, decode_err;

  sseg_scan_decoder #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .an_in(an_in), .sseg_in(sseg_in),
    .current_temp(current_temp), .changed_temp(changed_temp),
    .frame_valid(frame_valid), .decode_err(decode_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  int fv_cnt = 0, err_cnt = 0, both_cnt = 0;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_cnt++;
    if (decode_err === 1'b1) err_cnt++;
    if (frame_valid === 1'b1 && decode_err === 1'b1) both_cnt++;
  end

  logic [6:0] seg_tbl [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100};

  // Reference model: expected slot (0 = hunting), digits, published temps
  int         m_exp, m_cur, m_chg, m_efv, m_eer;
  int         m_dig [8];
  logic [7:0] m_last_an;
  bit         m_armed;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int dig_of(input logic [6:0] seg);
    for (int i = 0; i < 10; i++) if (seg_tbl[i] == seg) return i;
    return -1;
  endfunction

  function automatic logic [7:0] slot_an(input int k);
    logic [7:0] a;
    a = 8'hFF;
    a[k] = 1'b0;
    return a;
  endfunction

  function automatic logic [6:0] slot_seg(input int k, input int cur, input int chg);
    case (k)
      0, 4:    return SEG_F;
      1, 5:    return SEG_DEG;
      2:       return seg_tbl[cur % 10];
      3:       return seg_tbl[cur / 10];
      6:       return seg_tbl[chg % 10];
      default: return seg_tbl[chg / 10];
    endcase
  endfunction

  task automatic model_reset();
    m_exp = 0; m_cur = 0; m_chg = 0;
    m_last_an = 8'hFF; m_armed = 1'b1;
    for (int i = 0; i < 8; i++) m_dig[i] = 0;
  endtask

  task automatic model_accept(input logic [7:0] an, input logic [6:0] seg);
    int k, zeros, d;
    bit ok;
    if (an == 8'hFF) return;
    zeros = 0; k = 0;
    for (int i = 0; i < 8; i++) if (!an[i]) begin zeros++; k = i; end
    if (zeros != 1) begin m_eer++; m_exp = 0; return; end
    d = dig_of(seg);
    if (k == 2 || k == 3 || k == 6 || k == 7) ok = (d >= 0);
    else begin
`ifdef SSEG_SCAN_CHECK_EN
      ok = (k % 4 == 0) ? (seg == SEG_F) : (seg == SEG_DEG);
`else
      ok = 1'b1;
`endif
    end
    if (m_exp == 0) begin
      if (k == 0) begin
        if (ok) m_exp = 1; else m_eer++;
      end
    end else if (k == m_exp && ok) begin
      m_dig[k] = d;
      if (k == 7) begin
        m_efv++;
        m_cur = m_dig[3] * 10 + m_dig[2];
        m_chg = m_dig[7] * 10 + m_dig[6];
        m_exp = 0;
      end else m_exp++;
    end else if (k == 0 && ok) m_exp = 1;
    else begin m_eer++; m_exp = 0; end
  endtask

  // Hold one bus value for n clocks, then compare the DUT against the model
  task automatic step(input logic [7:0] an, input logic [6:0] seg, input int n);
    int fv0, er0;
    fv0 = fv_cnt; er0 = err_cnt;
    an_in = an; sseg_in = seg;
    repeat (n) @(negedge clk);
    m_efv = 0; m_eer = 0;
    if (an != m_last_an) m_armed = 1'b1;
    m_last_an = an;
    if (m_armed && n > SETTLE) begin
      m_armed = 1'b0;
      model_accept(an, seg);
    end
    check("frame_valid pulses", fv_cnt - fv0, m_efv);
    check("decode_err pulses", err_cnt - er0, m_eer);
    check("current_temp", current_temp, m_cur);
    check("changed_temp", changed_temp, m_chg);
  endtask

  task automatic send_slot(input int k, input logic [6:0] seg, input bit blanks);
    if (blanks && $urandom_range(0, 2) == 0) step(8'hFF, 7'($urandom), LONG);
    step(slot_an(k), seg, LONG);
  endtask

  task automatic send_frame(input int cur, input int chg, input bit blanks);
    for (int k = 0; k < 8; k++) send_slot(k, slot_seg(k, cur, chg), blanks);
  endtask

  task automatic do_reset_in_slot5();
    an_in = slot_an(5); sseg_in = SEG_DEG;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset current_temp", current_temp, 0);
    check("reset changed_temp", changed_temp, 0);
    check("reset frame_valid", frame_valid, 0);
    check("reset decode_err", decode_err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int cur, chg, var_k, a, b;
    logic [6:0] s;
    rst_n = 1'b0; an_in = 8'hFF; sseg_in = 7'h7F;
    model_reset();
    repeat (3) @(negedge clk);
    check("init current_temp", current_temp, 0);
    check("init changed_temp", changed_temp, 0);
    check("init frame_valid", frame_valid, 0);
    check("init decode_err", decode_err, 0);
    rst_n = 1'b1;
    step(8'hFF, 7'h7F, LONG);

    send_frame(72, 68, 1'b0);
    check("clean frame current 72", current_temp, 72);
    check("clean frame changed 68", changed_temp, 68);

    for (int k = 0; k < 8; k++) send_slot(k, (k == 3) ? 7'h7F : slot_seg(k, 41, 5), 1'b0);
    check("bad digit holds 72", current_temp, 72);
    send_frame(41, 5, 1'b1);

    send_slot(0, SEG_F, 1'b0); send_slot(1, SEG_DEG, 1'b0);
    send_slot(2, seg_tbl[3], 1'b0);
    for (int k = 4; k < 8; k++) send_slot(k, slot_seg(k, 13, 27), 1'b0);
    send_frame(13, 27, 1'b0);

    for (int k = 0; k < 8; k++) begin
      send_slot(k, slot_seg(k, 99, 0), 1'b0);
      if (k == 2) begin
        step(slot_an(2), slot_seg(2, 99, 0) ^ 7'h01, GLITCH);
        step(slot_an(2), slot_seg(2, 99, 0), LONG);
      end
    end

    step(8'b11110011, SEG_F, LONG);
    send_frame(50, 61, 1'b1);

    send_slot(0, SEG_DEG, 1'b0);
    for (int k = 1; k < 8; k++) send_slot(k, slot_seg(k, 8, 19), 1'b0);

    for (int k = 0; k < 5; k++) send_slot(k, slot_seg(k, 33, 44), 1'b0);
    do_reset_in_slot5();
    step(8'hFF, 7'h7F, LONG);
    send_slot(6, seg_tbl[4], 1'b0); send_slot(7, seg_tbl[4], 1'b0);
    send_frame(35, 90, 1'b0);
    check("post-reset current 35", current_temp, 35);

    for (int f = 0; f < 30; f++) begin
      cur = $urandom_range(0, 99); chg = $urandom_range(0, 99);
      var_k = $urandom_range(1, 7);
      case ($urandom_range(0, 5))
        2: for (int k = 0; k < 8; k++)
             send_slot(k, (k == var_k) ? 7'($urandom) : slot_seg(k, cur, chg), 1'b1);
        3: for (int k = 0; k < 8; k++)
             if (k != var_k) send_slot(k, slot_seg(k, cur, chg), 1'b1);
        4: begin
          a = $urandom_range(0, 7); b = (a + $urandom_range(1, 7)) % 8;
          for (int k = 0; k < 8; k++) begin
            if (k == var_k) step(~((8'd1 << a) | (8'd1 << b)), 7'($urandom), LONG);
            send_slot(k, slot_seg(k, cur, chg), 1'b1);
          end
        end
        5: for (int k = 0; k < 8; k++) begin
          s = slot_seg(k, cur, chg);
          send_slot(k, s, 1'b1);
          if (k == var_k) begin
            step(slot_an(k), s ^ 7'(1 << $urandom_range(0, 6)), GLITCH);
            step(slot_an(k), s, LONG);
          end
        end
        default: send_frame(cur, chg, 1'b1);
      endcase
    end

    check("frame_valid and decode_err overlap", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
